mod_counter_ctrl: RTL and testbench
===================================

# mod_counter_ctrl

Run controller for the team's modulo-N counter datapath. Holds a programmable modulus and repetition count, sequences start/stop of the counter core, and flags terminal counts and run completion. Sits between a register/config interface and the counter, so software-style configuration replaces compile-time `N`.

## Interface
- `WIDTH`, 4, counter and modulus width
- `DEF_MOD`, 10, modulus loaded at reset; must be ≤ 2^WIDTH
- `REP_W`, 8, repetition-count width

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-high reset
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config accepted when `cfg_valid & cfg_ready`
- `cfg_mod`  in  WIDTH  modulus M; 0 means 2^WIDTH
- `cfg_reps`  in  REP_W  periods per run; 0 means free-running
- `start`  in  1  begin run
- `stop`  in  1  abort run
- `busy`  out  1  high in RUN
- `count`  out  WIDTH  current counter value
- `wrap`  out  1  terminal-count flag
- `done`  out  1  one-cycle run-complete pulse

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `count`=0, modulus=DEF_MOD, reps=0, `busy`=0, `wrap`=0, `done`=0, `cfg_ready`=1.
- `cfg_ready` = (state==IDLE). A handshake latches `cfg_mod` and `cfg_reps` at that edge.
- IDLE: `start` moves to RUN and sets `count` to 0.
- If `cfg_valid` and `start` are both high in IDLE, the new config applies to the run being started.
- If `start` and `stop` are both high in IDLE, `stop` wins and the state stays IDLE.
- RUN: `count` increments every cycle.
  - Terminal value is M−1. At terminal, the next `count` is 0.
  - M=1: `count` stays 0 and every RUN cycle is terminal.
  - M=0: natural 2^WIDTH wrap.
  - `wrap` = RUN & (`count`==M−1). It is decoded from registers only, with no input-to-output path.
- Rep counter: cleared on entry to RUN and incremented on each terminal cycle.
  - If reps≠0 and a terminal cycle is the reps-th one, the next state is DONE.
  - If reps=0, the block runs until `stop`.
- DONE: `done`=1 and `count`=0 for exactly one cycle, then the state goes to IDLE unconditionally. `start` is ignored in DONE.
- `stop` in RUN: next state IDLE, `count`←0, no `done`. This holds even when `stop` coincides with the final terminal cycle.
- `start` during RUN is ignored. `cfg_valid` during RUN or DONE is not accepted.
- `rst` at any time, including mid-run, forces all reset values immediately. The latched config returns to DEF_MOD and reps 0.
- Width rules:
  - M−1 is computed in WIDTH bits, so M=0 gives terminal 2^WIDTH−1.
  - The rep comparison is REP_W bits. reps=2^REP_W−1 is legal.

## Timing
- `start` sampled at edge t → `busy`=1 and `count`=0 after t. `count` is 1 after t+1.
- Run length with reps=R and modulus M is R·M cycles in RUN. `done` is high in cycle R·M after the start edge.
- `wrap` is high in the same cycle `count` shows M−1.
- A config handshake at edge t is visible to a `start` at edge t or later.
- All outputs are registered or decoded from state registers. No combinational paths from inputs to outputs except none; `cfg_ready` depends on state only.

## Structure
- Package `mod_counter_pkg`:
  - state enum (IDLE, RUN, DONE)
  - default constants WIDTH, DEF_MOD, REP_W
- Sub-module `modn_ctr_core`:
  - inputs: `clk`, `rst`, `en`, `clr`, terminal value
  - outputs: `count`, `tc`
- The controller owns the FSM, config registers and rep counter, and drives `en`/`clr` to the core.

## Test plan
- Reset then `start`, default config → `count` 0..9 repeating. `wrap` high when `count`=9, every 10 cycles. `done` never fires.
- Config M=5, reps=3, then `start` → 15 RUN cycles, 3 `wrap` pulses, `done` in cycle 15, then IDLE with `cfg_ready`=1.
- M=1, reps=4 → `wrap` high for 4 consecutive cycles, `count` always 0, `done` on cycle 4. M=0, WIDTH=4, reps=1 → `count` 0..15, `done` at cycle 16.
- `stop` at `count`=3 mid-run, and `stop` on the final terminal cycle → IDLE next cycle, `count`=0, no `done`. `start`+`stop` together in IDLE → stays IDLE.
- `cfg_valid` with M=7 during RUN → `cfg_ready`=0 and the run keeps M=5. `cfg_valid`+`start` together in IDLE with M=3 → the run wraps at 2.
- Assert `rst` at `count`=4 mid-run → immediate IDLE, `count`=0, outputs at reset values. A following `start` uses DEF_MOD=10.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and default constants for the modulo-N counter run controller.
//   state_t      : controller FSM state encoding
//   MC_WIDTH     : default counter/modulus width
//   MC_DEF_MOD   : default modulus loaded at reset
//   MC_REP_W     : default repetition-count width
package mod_counter_pkg;

  localparam int MC_WIDTH   = 4;
  localparam int MC_DEF_MOD = 10;
  localparam int MC_REP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modn_ctr_core.sv
// Modulo-N counter core. Counts up while enabled and returns to zero after
// reaching the terminal value.
//   clk, rst : clock, async active-high reset
//   en       : advance the count this cycle
//   clr      : force count to zero (wins over en)
//   term     : terminal value (modulus - 1)
//   count    : current value
//   tc       : count equals terminal value (decoded from registers only)
module modn_ctr_core
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run controller for the modulo-N counter: holds the programmable modulus and
// repetition count, sequences the counter core and flags terminal counts and
// run completion.
//   clk, rst   : clock, async active-high reset
//   cfg_valid  : config offer; accepted when cfg_valid & cfg_ready
//   cfg_ready  : high in IDLE
//   cfg_mod    : modulus M (0 means 2^WIDTH)
//   cfg_reps   : periods per run (0 means free-running)
//   start/stop : begin / abort a run (stop wins)
//   busy       : high in RUN
//   count      : current counter value
//   wrap       : terminal-count flag, RUN & (count == M-1)
//   done       : one-cycle run-complete pulse
//
// state   | meaning
// IDLE    | waiting for start, config accepted
// RUN     | counter advancing, terminal cycles tallied
// DONE    | one-cycle completion pulse, then back to IDLE
module mod_counter_ctrl
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = MC_WIDTH,
  parameter int DEF_MOD = MC_DEF_MOD,
  parameter int REP_W   = MC_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done
);

  // A DEF_MOD of 2^WIDTH truncates to 0, which is the encoding for 2^WIDTH.
  localparam logic [WIDTH-1:0] DEF_MOD_W = WIDTH'(DEF_MOD);

  state_t           state;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] term;
  logic [REP_W-1:0] reps_r;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             tc;
  logic             en;
  logic             clr;

  // Modulus 0 wraps to all-ones, giving the natural 2^WIDTH period.
  assign term     = mod_r - 1'b1;
  assign rep_next = rep_cnt + 1'b1;

  // Counter is held at zero outside RUN and cleared on abort.
  assign en  = (state == ST_RUN);
  assign clr = (state != ST_RUN) | stop;

  modn_ctr_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .term  (term),
    .count (count),
    .tc    (tc)
  );

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign cfg_ready = (state == ST_IDLE);
  assign wrap      = busy & tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mod_r   <= DEF_MOD_W;
      reps_r  <= '0;
      rep_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            mod_r  <= cfg_mod;
            reps_r <= cfg_reps;
          end
          if (start && !stop) begin
            state   <= ST_RUN;
            rep_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (tc) begin
            rep_cnt <= rep_next;
            if ((reps_r != '0) && (rep_next == reps_r)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
module tb_mod_counter_ctrl;

  localparam int WIDTH   = 4;
  localparam int REP_W   = 8;
  localparam int DEF_MOD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_mod;
  logic [REP_W-1:0] cfg_reps;
  logic             start;
  logic             stop;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is described by the number of RUN cycles elapsed
  // since the start edge; everything else follows arithmetically.
  int m_mode;   // 0 idle, 1 run, 2 done
  int m_k;
  int m_mod;
  int m_reps;

  always #5 clk = ~clk;

  mod_counter_ctrl #(.WIDTH(WIDTH), .DEF_MOD(DEF_MOD), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mod   (cfg_mod),
    .cfg_reps  (cfg_reps),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .count     (count),
    .wrap      (wrap),
    .done      (done)
  );

  function automatic int period();
    return (m_mod == 0) ? (1 << WIDTH) : m_mod;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int p;
    p = period();
    chk("busy",      {31'd0, busy},      (m_mode == 1) ? 32'd1 : 32'd0);
    chk("done",      {31'd0, done},      (m_mode == 2) ? 32'd1 : 32'd0);
    chk("cfg_ready", {31'd0, cfg_ready}, (m_mode == 0) ? 32'd1 : 32'd0);
    chk("count",     32'(count),         (m_mode == 1) ? 32'(m_k % p) : 32'd0);
    chk("wrap",      {31'd0, wrap},      (m_mode == 1 && (m_k % p) == p - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_mod  = DEF_MOD;
    m_reps = 0;
  endtask

  task automatic model_edge();
    case (m_mode)
      0: begin
        if (cfg_valid) begin
          m_mod  = int'(cfg_mod);
          m_reps = int'(cfg_reps);
        end
        if (start && !stop) begin
          m_mode = 1;
          m_k    = 0;
        end
      end
      1: begin
        if (stop) m_mode = 0;
        else if (m_reps != 0 && m_k + 1 == m_reps * period()) m_mode = 2;
        else m_k++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic s, input logic p, input logic v,
                       input logic [WIDTH-1:0] m, input logic [REP_W-1:0] r);
    start     = s;
    stop      = p;
    cfg_valid = v;
    cfg_mod   = m;
    cfg_reps  = r;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic configure(input logic [WIDTH-1:0] m, input logic [REP_W-1:0] r);
    drive(1'b0, 1'b0, 1'b1, m, r);
    cycle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic kick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int wraps;
    int dones;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    model_reset();
    #2;
    check_outputs();
    chk("reset_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Default config: free-running modulo 10, done never fires.
    kick();
    wraps = 0;
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      cycle();
      if (wrap) wraps++;
      if (done) dones++;
    end
    chk("default_wraps", 32'(wraps), 32'd3);
    chk("default_no_done", 32'(dones), 32'd0);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    idle_cycles(2);

    // M=5, reps=3: 15 RUN cycles, 3 wraps, done in cycle 15.
    configure(4'd5, 8'd3);
    kick();
    wraps = 0;
    for (int i = 0; i < 14; i++) begin
      if (wrap) wraps++;
      cycle();
    end
    if (wrap) wraps++;
    chk("m5_wraps", 32'(wraps), 32'd3);
    cycle();
    chk("m5_done", {31'd0, done}, 32'd1);
    cycle();
    chk("m5_ready", {31'd0, cfg_ready}, 32'd1);

    // M=1, reps=4.
    configure(4'd1, 8'd4);
    kick();
    idle_cycles(6);

    // M=0 => period 16, reps=1.
    configure(4'd0, 8'd1);
    kick();
    idle_cycles(18);

    // Stop at count 3.
    configure(4'd5, 8'd3);
    kick();
    idle_cycles(3);
    chk("pre_stop_count", 32'(count), 32'd3);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    idle_cycles(2);

    // Stop on the final terminal cycle (count 4 of third period).
    kick();
    idle_cycles(14);
    chk("final_term_wrap", {31'd0, wrap}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    idle_cycles(2);

    // start+stop together in IDLE.
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    cycle();
    idle_cycles(1);

    // cfg offer during RUN is refused; run keeps M=5.
    kick();
    drive(1'b0, 1'b0, 1'b1, 4'd7, 8'd2);
    for (int i = 0; i < 16; i++) cycle();
    idle_cycles(2);

    // cfg+start together: new M=3 applies to this run.
    drive(1'b1, 1'b0, 1'b1, 4'd3, 8'd2);
    cycle();
    idle_cycles(8);

    // Maximum rep count with M=1.
    configure(4'd1, 8'd255);
    kick();
    idle_cycles(258);

    // Async reset mid-run at count 4, then default modulus returns.
    configure(4'd6, 8'd0);
    kick();
    idle_cycles(4);
    chk("pre_rst_count", 32'(count), 32'd4);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 1'b0;
    kick();
    idle_cycles(22);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
            WIDTH'($urandom_range(0, 15)), REP_W'($urandom_range(0, 3)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
